// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if
// CPU data-side SRAM-like bus (req / addr_ok / data_ok).
// The master is the pipeline (EX issues requests, MEM consumes responses).
// The slave is the responder that fronts the data block RAM.

interface data_sram_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_size,
        output data_sram_wstrb,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_addr_ok,
        input  data_sram_data_ok,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_size,
        input  data_sram_wstrb,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_addr_ok,
        output data_sram_data_ok,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder
// Responder end of the CPU data SRAM-like interface. Accepted requests go
// straight to a 1-cycle-read block RAM; responses come back in accept order
// after a programmable latency, with up to DEPTH requests outstanding.
// Optional feature: define DSRAM_RESP_RAND_DELAY_EN to add a pseudo-random
// extra delay (0..3 cycles, capped at 7 total) per request, drawn from a
// 32-bit Galois LFSR seeded with 1 at reset.

module data_sram_responder #(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    data_sram_responder_if.slave  bus,
    output logic                  ram_en,
    output logic [3:0]            ram_wen,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0]       BASE_DELAY = 3'(LATENCY - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Outstanding-request queue, one slot per possible in-flight request.
    // q_cap low means the slot was pushed last cycle and its load data is
    // still on ram_rdata rather than in q_rdata.
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] q_wr;
    logic [DEPTH-1:0] q_cap;
    logic [31:0]      q_rdata [DEPTH];
    logic [2:0]       q_delay [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;

    logic             addr_ok;
    logic             accept;
    logic             head_ready;
    logic             pop;
    logic [31:0]      head_rdata;
    logic [2:0]       push_delay;

    // Size and the address bits outside the word index never affect an access.
    logic unused_bits;
    assign unused_bits = ^{bus.data_sram_size,
                           bus.data_sram_addr[31:ADDR_W+2],
                           bus.data_sram_addr[1:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

`ifdef DSRAM_RESP_RAND_DELAY_EN
    logic [31:0] lfsr;
    logic [3:0]  rand_sum;

    // Galois LFSR for taps 32,22,2,1, free-running from a fixed seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 32'h1;
        end else begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
        end
    end

    assign rand_sum   = {1'b0, BASE_DELAY} + {2'b00, lfsr[1:0]};
    assign push_delay = (rand_sum > 4'd7) ? 3'd7 : rand_sum[2:0];
`else
    assign push_delay = BASE_DELAY;
`endif

    // Handshake and RAM drive. Acceptance uses the registered count only,
    // so a full queue refuses requests even in a cycle that pops.
    always_comb begin
        addr_ok    = 1'b0;
        accept     = 1'b0;
        head_ready = 1'b0;
        pop        = 1'b0;
        head_rdata = 32'h0;

        addr_ok    = !reset && (count != FULL_COUNT);
        accept     = bus.data_sram_req && addr_ok;
        head_ready = q_valid[head_ptr] && (q_delay[head_ptr] == 3'd0);
        pop        = !reset && head_ready;

        if (pop && !q_wr[head_ptr]) begin
            head_rdata = q_cap[head_ptr] ? q_rdata[head_ptr] : ram_rdata;
        end
    end

    assign bus.data_sram_addr_ok = addr_ok;
    assign bus.data_sram_data_ok = pop;
    assign bus.data_sram_rdata   = head_rdata;

    assign ram_en    = accept;
    assign ram_wen   = (accept && bus.data_sram_wr) ? bus.data_sram_wstrb : 4'b0000;
    assign ram_addr  = bus.data_sram_addr[ADDR_W+1:2];
    assign ram_wdata = bus.data_sram_wdata;

    // Queue maintenance: age every slot, capture fresh load data, then pop
    // the head and push the newly accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            q_valid  <= '0;
            q_wr     <= '0;
            q_cap    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_rdata[i] <= 32'h0;
                q_delay[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_valid[i] && (q_delay[i] != 3'd0)) begin
                    q_delay[i] <= q_delay[i] - 3'd1;
                end
                if (q_valid[i] && !q_cap[i]) begin
                    q_cap[i]   <= 1'b1;
                    q_rdata[i] <= q_wr[i] ? 32'h0 : ram_rdata;
                end
            end

            if (pop) begin
                q_valid[head_ptr] <= 1'b0;
                head_ptr          <= ptr_inc(head_ptr);
            end

            if (accept) begin
                q_valid[tail_ptr] <= 1'b1;
                q_wr[tail_ptr]    <= bus.data_sram_wr;
                q_cap[tail_ptr]   <= 1'b0;
                q_rdata[tail_ptr] <= 32'h0;
                q_delay[tail_ptr] <= push_delay;
                tail_ptr          <= ptr_inc(tail_ptr);
            end

            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder
// Four responders (DEPTH=2, LATENCY=1..4) share one stimulus set and one
// RAM model; 'sel' picks which responder sees the requests.

module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [1:0]  sel = 2'd0;
    int          cyc = 0;

    logic [3:0]  addr_ok_v;
    logic [3:0]  data_ok_v;
    logic [3:0]  ram_en_v;
    logic [31:0] rdata_v     [4];
    logic [3:0]  ram_wen_v   [4];
    logic [13:0] ram_addr_v  [4];
    logic [31:0] ram_wdata_v [4];
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] mem [0:16383];

    int          pass_count = 0;
    int          check_count = 0;

    int          acc_cyc [$];
    logic [1:0]  acc_rnd [$];
    int          rsp_cyc [$];
    logic [31:0] rsp_data [$];
    logic [1:0]  rnd_now;

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp accepts and responses.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_sram_responder_if bus ();

        assign bus.data_sram_req   = req && (sel == 2'(g));
        assign bus.data_sram_wr    = wr;
        assign bus.data_sram_size  = size;
        assign bus.data_sram_wstrb = wstrb;
        assign bus.data_sram_addr  = addr;
        assign bus.data_sram_wdata = wdata;

        data_sram_responder #(
            .DEPTH   (2),
            .LATENCY (g + 1),
            .ADDR_W  (14)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .bus       (bus),
            .ram_en    (ram_en_v[g]),
            .ram_wen   (ram_wen_v[g]),
            .ram_addr  (ram_addr_v[g]),
            .ram_wdata (ram_wdata_v[g]),
            .ram_rdata (ram_rdata)
        );

        assign addr_ok_v[g] = bus.data_sram_addr_ok;
        assign data_ok_v[g] = bus.data_sram_data_ok;
        assign rdata_v[g]   = bus.data_sram_rdata;
    end

`ifdef DSRAM_RESP_RAND_DELAY_EN
    logic [31:0] lfsr_model;

    // Reference LFSR: taps 32,22,2,1, seed 1, advancing every cycle.
    always @(posedge clk) begin
        if (reset) lfsr_model <= 32'h1;
        else       lfsr_model <= {1'b0, lfsr_model[31:1]} ^ (lfsr_model[0] ? 32'h8020_0003 : 32'h0);
    end
    assign rnd_now = lfsr_model[1:0];
`else
    assign rnd_now = 2'b00;
`endif

    // Synchronous 1-cycle-read RAM with byte write enables.
    always @(posedge clk) begin
        if (ram_en_v[sel]) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen_v[sel][b]) mem[ram_addr_v[sel]][8*b +: 8] <= ram_wdata_v[sel][8*b +: 8];
            end
            ram_rdata <= mem[ram_addr_v[sel]];
        end
    end

    // Log every accept and response of the selected responder.
    always @(negedge clk) begin
        if (req && addr_ok_v[sel]) begin
            acc_cyc.push_back(cyc);
            acc_rnd.push_back(rnd_now);
        end
        if (data_ok_v[sel]) begin
            rsp_cyc.push_back(cyc);
            rsp_data.push_back(rdata_v[sel]);
        end
    end

    // Hard stop in case a wait somewhere never finishes.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    endtask

    function automatic logic [31:0] rspDataAt(input int i);
        return (i < rsp_data.size()) ? rsp_data[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int rspCycAt(input int i);
        return (i < rsp_cyc.size()) ? rsp_cyc[i] : -1000;
    endfunction

    function automatic int accCycAt(input int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : -2000;
    endfunction

    function automatic int expectedDelay(input int lat, input logic [1:0] r);
        int d;
        d = lat - 1 + int'(r);
        return (d > 7) ? 7 : d;
    endfunction

    task automatic clearLog();
        acc_cyc.delete();
        acc_rnd.delete();
        rsp_cyc.delete();
        rsp_data.delete();
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Hold one request until accepted, checking the RAM drive on the accept cycle.
    task automatic applyStimulus(input logic is_wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        bit done;
        done  = 1'b0;
        req   = 1'b1;
        wr    = is_wr;
        addr  = a;
        wdata = d;
        wstrb = strb;
        size  = 2'd2;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (addr_ok_v[sel]) begin
                checkOutput("ram_en", 32'(ram_en_v[sel]), 32'h1);
                checkOutput("ram_wen", 32'(ram_wen_v[sel]), 32'(is_wr ? strb : 4'h0));
                checkOutput("ram_addr", 32'(ram_addr_v[sel]), 32'(a[15:2]));
                done = 1'b1;
            end
            nextCycle();
        end
        if (!done) checkOutput("accept_timeout", 32'h0, 32'h1);
        req = 1'b0;
    endtask

    // Wait for n responses, then a few quiet cycles to catch extras.
    task automatic waitResponses(input int n);
        int budget;
        budget = n * 12 + 20;
        while (rsp_cyc.size() < n && budget > 0) begin
            nextCycle();
            budget--;
        end
        repeat (3) nextCycle();
        checkOutput("rsp_count", 32'(rsp_cyc.size()), 32'(n));
    endtask

    // Responses in order: each after its own delay, never before the previous one.
    task automatic checkTiming(input string tag, input int lat);
        int prev;
        int e;
        prev = -1;
        for (int i = 0; i < acc_cyc.size(); i++) begin
            e = acc_cyc[i] + expectedDelay(lat, acc_rnd[i]) + 1;
            if (prev >= 0 && e <= prev) e = prev + 1;
            checkOutput($sformatf("%s_lat%0d", tag, i), 32'(rspCycAt(i) - acc_cyc[i]), 32'(e - acc_cyc[i]));
            prev = e;
        end
    endtask

    initial begin
        // Reset values.
        nextCycle();
        @(negedge clk);
        checkOutput("rst_addr_ok", 32'(addr_ok_v), 32'h0);
        checkOutput("rst_data_ok", 32'(data_ok_v), 32'h0);
        checkOutput("rst_rdata", rdata_v[0], 32'h0);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_addr_ok", 32'(addr_ok_v), 32'hF);
        checkOutput("idle_ram_en", 32'(ram_en_v), 32'h0);
        nextCycle();

        // Word write then read, LATENCY=1.
        sel = 2'd0;
        clearLog();
        applyStimulus(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
        waitResponses(1);
        checkOutput("t1_store_rdata", rspDataAt(0), 32'h0);
        checkTiming("t1_store", 1);
        clearLog();
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0);
        waitResponses(1);
        checkOutput("t1_load_rdata", rspDataAt(0), 32'hDEAD_BEEF);
        checkTiming("t1_load", 1);

        // Byte strobe merge, back to back.
        clearLog();
        applyStimulus(1'b1, 32'h20, 32'h1122_3344, 4'hF);
        applyStimulus(1'b1, 32'h20, 32'h00AA_0000, 4'b0100);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0);
        waitResponses(3);
        checkOutput("t2_store0_rdata", rspDataAt(0), 32'h0);
        checkOutput("t2_store1_rdata", rspDataAt(1), 32'h0);
        checkOutput("t2_load_rdata", rspDataAt(2), 32'h11AA_3344);
        checkTiming("t2", 1);

        // Preload for the following tests.
        clearLog();
        applyStimulus(1'b1, 32'h200, 32'hA0A0_A001, 4'hF);
        applyStimulus(1'b1, 32'h204, 32'hA0A0_A002, 4'hF);
        applyStimulus(1'b1, 32'h208, 32'hA0A0_A003, 4'hF);
        applyStimulus(1'b1, 32'h300, 32'h1234_5678, 4'hF);
        waitResponses(4);

        // Queue full, LATENCY=3: three loads with req held high.
        sel = 2'd2;
        clearLog();
        applyStimulus(1'b0, 32'h200, 32'h0, 4'h0);
        applyStimulus(1'b0, 32'h204, 32'h0, 4'h0);
        applyStimulus(1'b0, 32'h208, 32'h0, 4'h0);
        waitResponses(3);
        checkOutput("t3_acc_gap", 32'(accCycAt(1) - accCycAt(0)), 32'd1);
        checkOutput("t3_third_after_pop", 32'(accCycAt(2) - rspCycAt(0)), 32'd1);
        checkOutput("t3_rdata0", rspDataAt(0), 32'hA0A0_A001);
        checkOutput("t3_rdata1", rspDataAt(1), 32'hA0A0_A002);
        checkOutput("t3_rdata2", rspDataAt(2), 32'hA0A0_A003);
        checkTiming("t3", 3);

        // Store then load to the same address, LATENCY=2.
        sel = 2'd1;
        clearLog();
        applyStimulus(1'b1, 32'h300, 32'h5A5A_5A5A, 4'hF);
        applyStimulus(1'b0, 32'h300, 32'h0, 4'h0);
        waitResponses(2);
        checkOutput("t4_store_rdata", rspDataAt(0), 32'h0);
        checkOutput("t4_load_rdata", rspDataAt(1), 32'h5A5A_5A5A);
        checkTiming("t4", 2);

        // Reset with two loads in flight, LATENCY=4.
        sel = 2'd3;
        clearLog();
        applyStimulus(1'b0, 32'h200, 32'h0, 4'h0);
        applyStimulus(1'b0, 32'h204, 32'h0, 4'h0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_addr_ok", 32'(addr_ok_v[3]), 32'h0);
        checkOutput("t5_rst_data_ok", 32'(data_ok_v), 32'h0);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_post_addr_ok", 32'(addr_ok_v[3]), 32'h1);
        repeat (8) nextCycle();
        checkOutput("t5_no_rsp", 32'(rsp_cyc.size()), 32'h0);
        clearLog();
        applyStimulus(1'b0, 32'h208, 32'h0, 4'h0);
        waitResponses(1);
        checkOutput("t5_new_rdata", rspDataAt(0), 32'hA0A0_A003);
        checkTiming("t5", 4);

`ifdef DSRAM_RESP_RAND_DELAY_EN
        // Sixteen back-to-back loads with random extra delay, LATENCY=1.
        sel = 2'd0;
        clearLog();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
        waitResponses(16);
        clearLog();
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'h400 + 32'(4 * i), 32'h0, 4'h0);
        waitResponses(16);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("t6_rdata%0d", i), rspDataAt(i), 32'hC0DE_0000 + 32'(i));
        checkTiming("t6", 1);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
